bulls_cows_engine: RTL

//  Parametrised Bulls-and-Cows (xAyB) game controller. Sits between the keypad/value-entry logic and the

---
 rtl/bulls_cows_engine.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/bulls_cows_engine.sv
// bulls_cows_engine
// Bulls-and-Cows (xAyB) game controller placed between the keypad value-entry
// logic and the seven-segment display driver. It latches a secret, then
// successive guesses, scores each guess serially one digit per cycle, counts
// attempts against an optional limit and drives the display controls.
//
// Optional feature macro: BC_UNIQUE_DIGITS_EN
//   defined   : a COMMIT whose value repeats any digit is rejected (err pulse).
//   undefined : repeated digits are accepted and scored by the normal B rule.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   cmd_valid, cmd  command strobe; 0=NOP 1=COMMIT 2=ACK 3=ABORT
//   value_in        keypad digits, digit 0 in the LSBs
//   busy            high while a guess is being scored
//   result_vld      one-cycle pulse when num_a/num_b are updated
//   num_a, num_b    exact-position / wrong-position match counts
//   guess_cnt       guesses scored since the secret was set (saturating)
//   win, lose       level outputs while in WIN / LOSE
//   err             one-cycle pulse when a COMMIT is rejected
//   disp_value      value for the display driver
//   disp_off        display blank request
//   disp_mode       0=entry 1=congrat 2=secret entry 3=score
module bulls_cows_engine #(
    parameter int DIGITS    = 4,
    parameter int DW        = 4,
    parameter int RADIX     = 10,
    parameter int MAX_GUESS = 10,
    parameter int GCW       = 4,
    localparam int AW       = $clog2(DIGITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd,
    input  logic [DIGITS*DW-1:0] value_in,
    output logic                 busy,
    output logic                 result_vld,
    output logic [AW-1:0]        num_a,
    output logic [AW-1:0]        num_b,
    output logic [GCW-1:0]       guess_cnt,
    output logic                 win,
    output logic                 lose,
    output logic                 err,
    output logic [DIGITS*DW-1:0] disp_value,
    output logic                 disp_off,
    output logic [1:0]           disp_mode
);

    localparam int IW = $clog2(DIGITS + 1);
    localparam logic [1:0] CMD_COMMIT = 2'd1;
    localparam logic [1:0] CMD_ACK    = 2'd2;
    localparam logic [1:0] CMD_ABORT  = 2'd3;

    typedef enum logic [2:0] {
        ST_SET, ST_GUESS, ST_SCORE, ST_RESULT, ST_WIN, ST_LOSE
    } state_t;

    state_t                state_r, state_next;
    logic [DIGITS*DW-1:0]  secret_r, guess_r;
    logic [IW-1:0]         idx_r;
    logic [AW-1:0]         acc_a_r, acc_b_r;
    logic [AW-1:0]         num_a_r, num_b_r;
    logic [GCW-1:0]        guess_cnt_r;
    logic                  result_vld_r, busy_r, win_r, lose_r, err_r, disp_off_r;
    logic [1:0]            disp_mode_r;
    logic [DIGITS*DW-1:0]  disp_value_r;

    logic commit_s, ack_s, abort_s, legal_s, last_guess_s;
    logic load_secret_s, load_guess_s, finish_s, err_next;
    logic [1:0] hits_s;
    logic [AW-1:0] show_a_s, show_b_s;
    logic [DIGITS*DW-1:0] disp_value_next;
    logic disp_off_next;
    logic [1:0] disp_mode_next;

    // Every digit must be inside the alphabet (and unique when enabled).
    function automatic logic value_legal(input logic [DIGITS*DW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (32'(v[i*DW +: DW]) >= 32'(RADIX)) ok = 1'b0;
        end
`ifdef BC_UNIQUE_DIGITS_EN
        for (int i = 0; i < DIGITS; i++) begin
            for (int j = i + 1; j < DIGITS; j++) begin
                if (v[i*DW +: DW] == v[j*DW +: DW]) ok = 1'b0;
            end
        end
`endif
        return ok;
    endfunction

    // Scores the guess digit selected by idx: bit1 = bull, bit0 = cow.
    function automatic logic [1:0] digit_hits(input logic [DIGITS*DW-1:0] g,
                                              input logic [DIGITS*DW-1:0] s,
                                              input logic [IW-1:0] idx);
        logic bull, any;
        bull = 1'b0;
        any  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                bull = (g[i*DW +: DW] == s[i*DW +: DW]);
                for (int j = 0; j < DIGITS; j++) begin
                    if (j != i && g[i*DW +: DW] == s[j*DW +: DW]) any = 1'b1;
                end
            end
        end
        return {bull, !bull && any};
    endfunction

    // Result screen: low four digits are {A, 0xA, B, 0xB}, the rest all-ones.
    function automatic logic [DIGITS*DW-1:0] score_word(input logic [AW-1:0] a,
                                                        input logic [AW-1:0] b);
        logic [DIGITS*DW-1:0] w;
        w = '1;
        for (int k = 0; k < DIGITS; k++) begin
            case (k)
                0:       w[k*DW +: DW] = DW'(4'hB);
                1:       w[k*DW +: DW] = DW'(b);
                2:       w[k*DW +: DW] = DW'(4'hA);
                3:       w[k*DW +: DW] = DW'(a);
                default: w[k*DW +: DW] = '1;
            endcase
        end
        return w;
    endfunction

    assign commit_s     = cmd_valid && (cmd == CMD_COMMIT);
    assign ack_s        = cmd_valid && (cmd == CMD_ACK);
    assign abort_s      = cmd_valid && (cmd == CMD_ABORT);
    assign legal_s      = value_legal(value_in);
    assign hits_s       = digit_hits(guess_r, secret_r, idx_r);
    assign last_guess_s = (MAX_GUESS != 0) &&
                          ((32'(guess_cnt_r) + 32'd1) == 32'(MAX_GUESS));

    // Next-state decode; SCORE ignores every command, including ABORT.
    always_comb begin
        state_next    = state_r;
        err_next      = 1'b0;
        load_secret_s = 1'b0;
        load_guess_s  = 1'b0;
        finish_s      = 1'b0;
        case (state_r)
            ST_SET, ST_GUESS: begin
                if (abort_s) begin
                    state_next = ST_SET;
                end else if (commit_s && legal_s) begin
                    state_next    = (state_r == ST_SET) ? ST_GUESS : ST_SCORE;
                    load_secret_s = (state_r == ST_SET);
                    load_guess_s  = (state_r == ST_GUESS);
                end else begin
                    err_next = commit_s;
                end
            end
            ST_SCORE: begin
                if (idx_r == IW'(DIGITS)) begin
                    finish_s = 1'b1;
                    if (acc_a_r == AW'(DIGITS)) state_next = ST_WIN;
                    else if (last_guess_s)      state_next = ST_LOSE;
                    else                        state_next = ST_RESULT;
                end else begin
                    state_next = ST_SCORE;
                end
            end
            ST_RESULT: begin
                if (abort_s)    state_next = ST_SET;
                else if (ack_s) state_next = ST_GUESS;
                else            state_next = ST_RESULT;
            end
            ST_WIN, ST_LOSE: begin
                if (abort_s || ack_s) state_next = ST_SET;
                else                  state_next = state_r;
            end
            default: state_next = ST_SET;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_SET;
        else     state_r <= state_next;
    end

    // Secret/guess latches and the serial scoring datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            secret_r <= '0;
            guess_r  <= '0;
            idx_r    <= '0;
            acc_a_r  <= '0;
            acc_b_r  <= '0;
        end else begin
            if (load_secret_s) secret_r <= value_in;
            if (load_guess_s)  guess_r  <= value_in;
            if (load_guess_s || (abort_s && state_r != ST_SCORE)) begin
                idx_r   <= '0;
                acc_a_r <= '0;
                acc_b_r <= '0;
            end else if (state_r == ST_SCORE && !finish_s) begin
                idx_r   <= idx_r + IW'(1);
                acc_a_r <= acc_a_r + AW'(hits_s[1]);
                acc_b_r <= acc_b_r + AW'(hits_s[0]);
            end
        end
    end

    // Published score, result strobe and saturating attempt counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_a_r      <= '0;
            num_b_r      <= '0;
            result_vld_r <= 1'b0;
            guess_cnt_r  <= '0;
        end else begin
            result_vld_r <= finish_s;
            if (finish_s) begin
                num_a_r <= acc_a_r;
                num_b_r <= acc_b_r;
            end
            if (load_secret_s)
                guess_cnt_r <= '0;
            else if (finish_s && guess_cnt_r != {GCW{1'b1}})
                guess_cnt_r <= guess_cnt_r + GCW'(1);
        end
    end

    // Display content follows the state being entered so it tracks state_r.
    always_comb begin
        show_a_s        = finish_s ? acc_a_r : num_a_r;
        show_b_s        = finish_s ? acc_b_r : num_b_r;
        disp_value_next = '1;
        disp_off_next   = 1'b0;
        disp_mode_next  = 2'd3;
        case (state_next)
            ST_SET:    begin disp_value_next = value_in; disp_mode_next = 2'd2; end
            ST_GUESS:  begin disp_value_next = value_in; disp_mode_next = 2'd0; end
            ST_SCORE:  disp_off_next = 1'b1;
            ST_RESULT: disp_value_next = score_word(show_a_s, show_b_s);
            ST_WIN:    disp_mode_next = 2'd1;
            ST_LOSE:   disp_mode_next = 2'd3;
            default:   disp_off_next = 1'b1;
        endcase
    end

    // Registered status and display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r       <= 1'b0;
            win_r        <= 1'b0;
            lose_r       <= 1'b0;
            err_r        <= 1'b0;
            disp_value_r <= '1;
            disp_off_r   <= 1'b1;
            disp_mode_r  <= 2'd2;
        end else begin
            busy_r       <= (state_next == ST_SCORE);
            win_r        <= (state_next == ST_WIN);
            lose_r       <= (state_next == ST_LOSE);
            err_r        <= err_next;
            disp_value_r <= disp_value_next;
            disp_off_r   <= disp_off_next;
            disp_mode_r  <= disp_mode_next;
        end
    end

    assign busy       = busy_r;
    assign result_vld = result_vld_r;
    assign num_a      = num_a_r;
    assign num_b      = num_b_r;
    assign guess_cnt  = guess_cnt_r;
    assign win        = win_r;
    assign lose       = lose_r;
    assign err        = err_r;
    assign disp_value = disp_value_r;
    assign disp_off   = disp_off_r;
    assign disp_mode  = disp_mode_r;

endmodule
